// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared constants and helpers for the RAM arbiter
package ram_arb_pkg;

    localparam logic        RstEnable   = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    // Master indices into the packed request/address/data buses
    localparam logic [1:0] M_DBG  = 2'd0;
    localparam logic [1:0] M_CORE = 2'd1;
    localparam logic [1:0] M_DMA  = 2'd2;

    // Last-served value out of reset: makes the debug master win first
    localparam logic [1:0] LastReset = M_DMA;

    // One-hot grant to master index; an all-zero grant maps to M_DBG
    function automatic logic [1:0] onehot3_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = M_DBG;
        if (oh[M_CORE]) idx = M_CORE;
        if (oh[M_DMA])  idx = M_DMA;
        return idx;
    endfunction

endpackage

// File: rtl/ram_arb_rr_pick3.sv
// rtl/ram_arb_rr_pick3.sv - three-way round-robin winner selection
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] gnt
);

    logic [1:0] start;
    logic [1:0] idx;

    // Search upward from the master after the last one served, wrapping at 3
    always_comb begin
        start = (last >= 2'd2) ? 2'd0 : last + 2'd1;
        gnt   = 3'b000;
        idx   = start;
        for (int i = 0; i < 3; i++) begin
            if (gnt == 3'b000 && req[idx]) begin
                gnt[idx] = 1'b1;
            end
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
    end

endmodule

// File: rtl/ram_arb.sv
// rtl/ram_arb.sv - round-robin arbiter sharing one single-port RAM among three masters
module ram_arb
    import ram_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int NM = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM-1:0]    m_req_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM*AW-1:0] m_addr_i,
    input  logic [NM*DW-1:0] m_data_i,
    output logic [DW-1:0]    m_data_o,
    output logic [NM-1:0]    m_ack_o,
    output logic             ram_req_o,
    output logic             ram_we_o,
    output logic [AW-1:0]    ram_addr_o,
    output logic [DW-1:0]    ram_data_o,
    input  logic [DW-1:0]    ram_data_i,
    output logic             hold_o
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]    state;
    logic [NM-1:0] gnt;
    logic [1:0]    last;
    logic [2:0]    pick;

    rr_pick3 u_pick (
        .req  (m_req_i),
        .last (last),
        .gnt  (pick)
    );

    // Two-state sequencer: latch the winner in IDLE, spend exactly one cycle in ACCESS.
    // A granted master that has dropped its request by ACCESS does not advance the rotation.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state <= ST_IDLE;
            gnt   <= '0;
            last  <= LastReset;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|m_req_i) begin
                        gnt   <= pick;
                        state <= ST_ACCESS;
                    end
                end
                default: begin
                    if (|(gnt & m_req_i)) begin
                        last <= onehot3_idx(gnt);
                    end
                    gnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Route the granted master to the RAM during ACCESS; everything is quiet otherwise.
    // Ack is suppressed under reset, but a write already on the RAM pins still lands.
    always_comb begin
        ram_req_o  = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_data_o = '0;
        m_data_o   = '0;
        m_ack_o    = '0;
        for (int k = 0; k < NM; k++) begin
            if (state == ST_ACCESS && gnt[k]) begin
                ram_addr_o = m_addr_i[k*AW +: AW];
                ram_data_o = m_data_i[k*DW +: DW];
                ram_req_o  = m_req_i[k];
                ram_we_o   = m_req_i[k] & (m_we_i[k] == WriteEnable);
                m_data_o   = ram_data_i;
                m_ack_o[k] = m_req_i[k] & (rst != RstEnable);
            end
        end
    end

    assign hold_o = |(m_req_i & ~m_ack_o);

endmodule
